// File: rtl/coder_pkg.sv
// Shared definitions for the request encoder and the matching 3:8 decoder.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   NUM_IN  number of request lines (this revision: 8)
//   CODE_W  binary code width, equal to $clog2(NUM_IN)
//   onehot  code -> NUM_IN-bit one-hot, used on both sides of the code/one-hot round trip
package coder_pkg;

  localparam int NUM_IN = 8;
  localparam int CODE_W = 3;

  function automatic logic [NUM_IN-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [NUM_IN-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_sel8.sv
// Combinational 8-input priority selector: binary index of the winning set bit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   in   [7:0]  candidate mask
//   idx  [2:0]  winning index (HIGH_PRI=1: highest set bit, 0: lowest); 0 when in==0
//   any         at least one bit of in is set
module prio_sel8 #(
  parameter int HIGH_PRI = 1
) (
  input  logic [7:0] in,
  output logic [2:0] idx,
  output logic       any
);

  // The scan direction is chosen so the last match written is the winner.
  always_comb begin
    idx = 3'd0;
    any = |in;
    if (HIGH_PRI != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (in[i]) idx = i[2:0];
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (in[i]) idx = i[2:0];
      end
    end
  end

endmodule

// File: rtl/irq_encoder_8to3.sv
// Sticky 8-line request collector issuing the binary index of the winning pending request.
// Latency: req sampled at an edge -> pending after that edge -> out_valid one edge later (when idle).
// Backpressure: a presented code holds while out_ready=0 (no preemption); accept reloads back-to-back.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         capture/issue enable (a presented code stays valid while en=0)
//   clr        synchronous flush of pending, out_valid and coalesced; overrides out_ready
//   req        level-sampled request lines
//   out_code   index of the presented request (holds its last value while out_valid=0)
//   out_valid  out_code is valid
//   out_ready  consumer accepts out_code this cycle
//   pending    registered sticky request mask
//   coalesced  1-cycle pulse: a request was sampled while its bit was already pending
module irq_encoder_8to3
  import coder_pkg::*;
#(
  parameter int HIGH_PRI = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_IN-1:0] req,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NUM_IN-1:0] pending,
  output logic              coalesced
);

  logic              acc;
  logic [NUM_IN-1:0] acc_mask;
  logic [NUM_IN-1:0] req_en;
  logic [NUM_IN-1:0] pend_left;
  logic [CODE_W-1:0] cur_idx;
  logic              cur_any;
  logic [CODE_W-1:0] nxt_idx;
  logic              nxt_any;

  logic [NUM_IN-1:0] pending_nxt;
  logic              coalesced_nxt;
  logic [CODE_W-1:0] code_nxt;
  logic              valid_nxt;

  assign acc       = out_valid & out_ready;
  assign acc_mask  = acc ? onehot(out_code) : '0;
  assign req_en    = req & {NUM_IN{en}};
  // What remains pending once this cycle's accepted request is retired.
  assign pend_left = pending & ~acc_mask;

  // Selection for the idle case (nothing presented, so nothing retires).
  prio_sel8 #(.HIGH_PRI(HIGH_PRI)) u_sel_cur (
    .in  (pending),
    .idx (cur_idx),
    .any (cur_any)
  );

  // Selection for the back-to-back case, excluding the bit being accepted.
  prio_sel8 #(.HIGH_PRI(HIGH_PRI)) u_sel_nxt (
    .in  (pend_left),
    .idx (nxt_idx),
    .any (nxt_any)
  );

  always_comb begin
    // A request on the bit being retired re-arms it (set wins over clear); it is
    // a fresh request, not a coalesced one.
    pending_nxt   = pend_left | req_en;
    coalesced_nxt = |(req_en & pend_left);
    code_nxt      = out_code;
    valid_nxt     = out_valid;

    if (!out_valid) begin
      if (en && cur_any) begin
        code_nxt  = cur_idx;
        valid_nxt = 1'b1;
      end
    end else if (out_ready) begin
      // Requests captured this same cycle are not yet visible here; they are
      // picked up from pending on the following idle cycle.
      if (en && nxt_any) begin
        code_nxt  = nxt_idx;
        valid_nxt = 1'b1;
      end else begin
        valid_nxt = 1'b0;
      end
    end
    // Stall: code and valid hold, even if a higher-priority request arrives.

    if (clr) begin
      pending_nxt   = '0;
      coalesced_nxt = 1'b0;
      valid_nxt     = 1'b0;
      code_nxt      = out_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      coalesced <= 1'b0;
      out_code  <= '0;
      out_valid <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      coalesced <= coalesced_nxt;
      out_code  <= code_nxt;
      out_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// Directed bench for irq_encoder_8to3: one highest-priority and one lowest-priority instance
// share stimulus; expected values are hand-computed, accepted codes are tallied per bit.
module tb_irq_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [7:0] req;
  logic       out_ready;

  logic [2:0] out_code;
  logic       out_valid;
  logic [7:0] pending;
  logic       coalesced;

  logic [2:0] lo_code;
  logic       lo_valid;
  logic [7:0] lo_pending;
  logic       lo_coalesced;

  int n_assert = 0;
  int n_fail   = 0;
  int issued[8];
  int base[8];

  irq_encoder_8to3 #(.HIGH_PRI(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .req       (req),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .coalesced (coalesced)
  );

  irq_encoder_8to3 #(.HIGH_PRI(0)) dut_lo (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .req       (req),
    .out_code  (lo_code),
    .out_valid (lo_valid),
    .out_ready (out_ready),
    .pending   (lo_pending),
    .coalesced (lo_coalesced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 8; i++) issued[i] = 0;
  end

  // Tally every code the high-priority instance hands over (accepted at the next edge).
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clr) issued[out_code] = issued[out_code] + 1;
  end

  function automatic logic [7:0] dec3to8(input logic [2:0] c);
    logic [7:0] r;
    r = 8'h01 << c;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 8; i++) base[i] = issued[i];
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; req = 8'h00; out_ready = 1'b0;
    step(); step();
    chk("rst_pending",   32'(pending),   32'h0);
    chk("rst_valid",     32'(out_valid), 32'h0);
    chk("rst_code",      32'(out_code),  32'h0);
    chk("rst_coalesced", 32'(coalesced), 32'h0);
    rst_n = 1'b1;
    step();

    // 1: async reset while a code is presented and pending=A5
    req = 8'hA5;
    step();
    req = 8'h00;
    step();
    chk("t1_pending_a5", 32'(pending),   32'hA5);
    chk("t1_valid",      32'(out_valid), 32'h1);
    chk("t1_code7",      32'(out_code),  32'h7);
    chk("t1_lo_code0",   32'(lo_code),   32'h0);
    rst_n = 1'b0;
    #1;
    chk("t1_arst_pending", 32'(pending),    32'h0);
    chk("t1_arst_valid",   32'(out_valid),  32'h0);
    chk("t1_arst_code",    32'(out_code),   32'h0);
    chk("t1_arst_lo_pend", 32'(lo_pending), 32'h0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("t1_idle_valid",   32'(out_valid), 32'h0);
    chk("t1_idle_pending", 32'(pending),   32'h0);

    // 2: single request, consumer always ready
    snap();
    out_ready = 1'b1;
    req = 8'h20;
    step();
    req = 8'h00;
    chk("t2_pend_t1",  32'(pending),   32'h20);
    chk("t2_valid_t1", 32'(out_valid), 32'h0);
    step();
    chk("t2_valid_t2", 32'(out_valid), 32'h1);
    chk("t2_code5",    32'(out_code),  32'h5);
    chk("t2_roundtrip", 32'(dec3to8(out_code)), 32'h20);
    step();
    chk("t2_valid_off", 32'(out_valid), 32'h0);
    chk("t2_pend_zero", 32'(pending),   32'h0);
    chk("t2_once_b5",   32'(issued[5] - base[5]), 32'h1);

    // 3: priority drain, both priority senses
    clr = 1'b1;
    step();
    clr = 1'b0;
    snap();
    req = 8'h91;
    step();
    req = 8'h00;
    step();
    chk("t3_hi_a",   32'(out_code), 32'h7);
    chk("t3_lo_a",   32'(lo_code),  32'h0);
    chk("t3_rt_a",   32'(dec3to8(out_code)), 32'h80);
    step();
    chk("t3_hi_b",   32'(out_code), 32'h4);
    chk("t3_lo_b",   32'(lo_code),  32'h4);
    chk("t3_valid_b", 32'(out_valid & lo_valid), 32'h1);
    step();
    chk("t3_hi_c",   32'(out_code), 32'h0);
    chk("t3_lo_c",   32'(lo_code),  32'h7);
    chk("t3_rt_c",   32'(dec3to8(lo_code)), 32'h80);
    step();
    chk("t3_hi_done",  32'(out_valid),  32'h0);
    chk("t3_lo_done",  32'(lo_valid),   32'h0);
    chk("t3_lo_pend",  32'(lo_pending), 32'h0);
    chk("t3_once_b0",  32'(issued[0] - base[0]), 32'h1);
    chk("t3_once_b4",  32'(issued[4] - base[4]), 32'h1);
    chk("t3_once_b7",  32'(issued[7] - base[7]), 32'h1);

    // 4: stall holds the presented code, no preemption
    out_ready = 1'b0;
    req = 8'h02;
    step();
    req = 8'h00;
    step();
    chk("t4_code1", 32'(out_code), 32'h1);
    req = 8'h80;
    step();
    req = 8'h00;
    step();
    chk("t4_stall_code",  32'(out_code),  32'h1);
    chk("t4_stall_valid", 32'(out_valid), 32'h1);
    chk("t4_stall_pend",  32'(pending),   32'h82);
    out_ready = 1'b1;
    step();
    chk("t4_next_code7", 32'(out_code),  32'h7);
    chk("t4_next_valid", 32'(out_valid), 32'h1);
    chk("t4_next_pend",  32'(pending),   32'h80);
    step();
    chk("t4_done_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // 5: set wins on the accepted bit; repeated request while pending coalesces
    snap();
    req = 8'h08;
    step();
    req = 8'h00;
    step();
    chk("t5_code3", 32'(out_code), 32'h3);
    out_ready = 1'b1;
    req = 8'h08;
    step();
    req = 8'h00;
    chk("t5_setwin_pend",  32'(pending),   32'h08);
    chk("t5_setwin_valid", 32'(out_valid), 32'h0);
    chk("t5_setwin_coal",  32'(coalesced), 32'h0);
    step();
    chk("t5_reissue_valid", 32'(out_valid), 32'h1);
    chk("t5_reissue_code",  32'(out_code),  32'h3);
    out_ready = 1'b0;
    req = 8'h08;
    step();
    req = 8'h00;
    chk("t5_coal_pulse", 32'(coalesced), 32'h1);
    step();
    chk("t5_coal_drop",  32'(coalesced), 32'h0);
    out_ready = 1'b1;
    step();
    chk("t5_drain_valid", 32'(out_valid), 32'h0);
    chk("t5_drain_pend",  32'(pending),   32'h0);
    chk("t5_twice_b3",    32'(issued[3] - base[3]), 32'h2);

    // 6: enable gating and synchronous clear
    snap();
    out_ready = 1'b0;
    req = 8'h01;
    step();
    req = 8'h00;
    en = 1'b0;
    step();
    chk("t6_noissue_valid", 32'(out_valid), 32'h0);
    chk("t6_noissue_pend",  32'(pending),   32'h01);
    req = 8'hFF;
    step();
    req = 8'h00;
    chk("t6_en0_pend",  32'(pending),   32'h01);
    chk("t6_en0_valid", 32'(out_valid), 32'h0);
    chk("t6_en0_coal",  32'(coalesced), 32'h0);
    en = 1'b1;
    step();
    chk("t6_en1_valid", 32'(out_valid), 32'h1);
    chk("t6_en1_code",  32'(out_code),  32'h0);
    req = 8'h0E;
    step();
    req = 8'h00;
    chk("t6_pend_0f",  32'(pending),  32'h0F);
    chk("t6_hold_code", 32'(out_code), 32'h0);
    clr = 1'b1;
    out_ready = 1'b1;
    step();
    clr = 1'b0;
    out_ready = 1'b0;
    chk("t6_clr_pend",  32'(pending),   32'h0);
    chk("t6_clr_valid", 32'(out_valid), 32'h0);
    chk("t6_clr_coal",  32'(coalesced), 32'h0);
    chk("t6_clr_code_held", 32'(out_code), 32'h0);
    step();
    chk("t6_after_valid", 32'(out_valid), 32'h0);
    chk("t6_clr_no_accept", 32'(issued[0] - base[0]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
